de1soc_system: RTL and testbench



---
 rtl/de1soc_system.sv | 243 ++++++++++++++++++++++++
 tb/tb_de1soc_system.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/de1soc_system.sv
// DE1-SoC top: 3-stage 16-bit pipelined core, dual-port program/data
// RAM, and memory-mapped HEX/LEDR/SW with a kill store at 0xFFFF.
module de1soc_system #(
   parameter string INIT_FILE = "program.hex",
   parameter int    MEM_WORDS = 256
) (
   input  logic       CLOCK_50,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic [6:0] HEX2,
   output logic [6:0] HEX3,
   output logic [6:0] HEX4,
   output logic [6:0] HEX5,
   input  logic [3:0] KEY,
   output logic [9:0] LEDR,
   input  logic [9:0] SW
);

   typedef struct packed {
      logic        v;
      logic [15:0] pc;
   } if_de_t;

   typedef struct packed {
      logic        v;
      logic        wr;
      logic        ld;
      logic        st;
      logic [2:0]  rd;
      logic [15:0] res;
      logic [15:0] addr;
   } de_mw_t;

   localparam int          AW      = $clog2(MEM_WORDS);
   localparam logic [15:0] RAM_TOP = 16'(MEM_WORDS);
   localparam logic [15:0] KILL    = 16'hFFFF;

   logic rst;
   logic unused_key;
   assign rst        = ~KEY[3];
   assign unused_key = &{1'b0, KEY[2:0]};

   logic [15:0] mem [MEM_WORDS];

   logic [15:0] pc;
   logic        halted;
   logic        z;
   logic [15:0] r [8];
   logic [6:0]  hex [6];
   logic [9:0]  ledr;
   if_de_t      fd;
   de_mw_t      mw;
   de_mw_t      nx;
   logic [15:0] iw;
   logic [15:0] dq;

   logic        WriteData;
   logic [15:0] DataAddr;

   logic [2:0]  op;
   logic [2:0]  rx;
   logic [2:0]  ry;
   logic        m;
   logic [8:0]  d;
   logic [15:0] xv;
   logic [15:0] yv;
   logic [15:0] opv;
   logic [15:0] tgt;
   logic [15:0] ldv;
   logic [15:0] wbv;
   logic        setz;
   logic        take;
   logic        use_x;
   logic        use_y;
   logic        stall;
   logic        kill_de;
   logic        kill_mw;
   logic        go;
   logic        fe;
   logic        mw_ram;

   assign op  = iw[15:13];
   assign m   = iw[12];
   assign rx  = iw[11:9];
   assign ry  = iw[2:0];
   assign d   = iw[8:0];
   assign tgt = fd.pc + 16'd1 + {{7{d[8]}}, d};

   assign WriteData = mw.v && mw.st;
   assign DataAddr  = mw.addr;
   assign mw_ram    = mw.addr < RAM_TOP;

   always_comb begin
      ldv = '0;
      if (mw_ram)
         ldv = dq;
      else if (mw.addr[15:3] == 13'h0200 && mw.addr[2:0] < 3'd6)
         ldv = {9'b0, hex[mw.addr[2:0]]};
      else if (mw.addr == 16'h2000)
         ldv = {6'b0, ledr};
      else if (mw.addr == 16'h3000)
         ldv = {6'b0, SW};
   end

   assign wbv = mw.ld ? ldv : mw.res;

   // Full bypass from M/W; a load there stalls its consumer instead.
   assign xv  = (mw.v && mw.wr && mw.rd == rx) ? wbv : r[rx];
   assign yv  = (mw.v && mw.wr && mw.rd == ry) ? wbv : r[ry];
   assign opv = m ? {7'b0, d} : yv;

   always_comb begin
      nx      = '0;
      nx.v    = fd.v;
      nx.rd   = rx;
      nx.addr = yv;
      setz    = 1'b0;
      take    = 1'b0;
      use_x   = 1'b0;
      use_y   = 1'b0;
      unique case (1'b1)
         op == 3'b000: begin
            nx.wr  = 1'b1;
            nx.res = opv;
            use_y  = ~m;
         end
         op == 3'b001 && m: begin
            nx.wr  = 1'b1;
            nx.res = {d[7:0], 8'h00};
         end
         op == 3'b001 && !m: begin
            take = fd.v && (rx == 3'd0 ||
                            (rx == 3'd1 && z) ||
                            (rx == 3'd2 && !z));
         end
         op == 3'b010: begin
            nx.wr  = 1'b1;
            nx.res = xv + opv;
            setz   = 1'b1;
            use_x  = 1'b1;
            use_y  = ~m;
         end
         op == 3'b011: begin
            nx.wr  = 1'b1;
            nx.res = xv - opv;
            setz   = 1'b1;
            use_x  = 1'b1;
            use_y  = ~m;
         end
         op == 3'b110: begin
            nx.wr  = 1'b1;
            nx.res = xv & opv;
            setz   = 1'b1;
            use_x  = 1'b1;
            use_y  = ~m;
         end
         op == 3'b100: begin
            nx.wr = 1'b1;
            nx.ld = 1'b1;
            use_y = 1'b1;
         end
         op == 3'b101: begin
            nx.st  = 1'b1;
            nx.res = xv;
            use_x  = 1'b1;
            use_y  = 1'b1;
         end
         default: ;
      endcase
   end

   assign stall   = fd.v && mw.v && mw.ld &&
                    ((use_x && rx == mw.rd) ||
                     (use_y && ry == mw.rd));
   assign kill_de = fd.v && nx.st && yv == KILL && !stall;
   assign kill_mw = mw.v && mw.st && mw.addr == KILL;
   assign go      = !halted && !kill_mw;
   assign fe      = go && !stall && !take && !kill_de;

   always_ff @(posedge CLOCK_50) begin
      if (fe)
         iw <= (pc < RAM_TOP) ? mem[pc[AW-1:0]] : '0;
   end

   // Same-address store in M/W wins over the stale RAM word.
   always_ff @(posedge CLOCK_50) begin
      if (mw.v && mw.st && mw.addr == nx.addr)
         dq <= mw.res;
      else if (nx.addr < RAM_TOP)
         dq <= mem[nx.addr[AW-1:0]];
      else
         dq <= '0;
   end

   always_ff @(posedge CLOCK_50) begin
      if (WriteData && mw_ram)
         mem[mw.addr[AW-1:0]] <= mw.res;
   end

   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         pc     <= '0;
         fd     <= '0;
         mw     <= '0;
         z      <= 1'b0;
         halted <= 1'b0;
         ledr   <= '0;
         for (int i = 0; i < 8; i++) r[i] <= '0;
         for (int i = 0; i < 6; i++) hex[i] <= 7'h7F;
      end else begin
         if (kill_mw) halted <= 1'b1;
         if (go) begin
            if (take || kill_de) begin
               fd.v <= 1'b0;
               if (take) pc <= tgt;
            end else if (!stall) begin
               fd.v  <= 1'b1;
               fd.pc <= pc;
               pc    <= pc + 16'd1;
            end
         end
         mw <= (go && !stall) ? nx : '0;
         if (go && !stall && fd.v && setz)
            z <= (nx.res == 16'h0);
         if (mw.v && mw.wr) r[mw.rd] <= wbv;
         if (WriteData) begin
            if (mw.addr[15:3] == 13'h0200 && mw.addr[2:0] < 3'd6)
               hex[mw.addr[2:0]] <= mw.res[6:0];
            if (mw.addr == 16'h2000)
               ledr <= mw.res[9:0];
         end
      end
   end

   assign HEX0 = hex[0];
   assign HEX1 = hex[1];
   assign HEX2 = hex[2];
   assign HEX3 = hex[3];
   assign HEX4 = hex[4];
   assign HEX5 = hex[5];
   assign LEDR = ledr;

endmodule

// File: tb/tb_de1soc_system.sv
// Directed bench for de1soc_system: loads small programs into RAM,
// runs each to its kill store and checks architectural results.
module tb_de1soc_system;

   logic       clk = 1'b0;
   logic [3:0] KEY;
   logic [9:0] SW;
   logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
   logic [9:0] LEDR;

   always #5 clk = ~clk;

   de1soc_system #(.INIT_FILE(""), .MEM_WORDS(256)) dut (
      .CLOCK_50(clk),
      .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
      .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
      .KEY(KEY), .LEDR(LEDR), .SW(SW)
   );

   localparam logic [2:0] MV  = 3'd0;
   localparam logic [2:0] MVT = 3'd1;
   localparam logic [2:0] ADD = 3'd2;
   localparam logic [2:0] SUB = 3'd3;
   localparam logic [2:0] LD  = 3'd4;
   localparam logic [2:0] ST  = 3'd5;
   localparam logic [2:0] AND = 3'd6;
   localparam logic [15:0] NOP = 16'hE000;

   int n_cmp = 0;
   int n_bad = 0;
   logic [15:0] pg [$];
   int kill_cyc, n_kill, n_led, n_late, led_cyc, halt_c;

   function automatic logic [15:0] ii(input logic [2:0] o,
                                      input logic [2:0] x,
                                      input logic [8:0] v);
      return {o, 1'b1, x, v};
   endfunction

   function automatic logic [15:0] rr(input logic [2:0] o,
                                      input logic [2:0] x,
                                      input logic [2:0] y);
      return {o, 1'b0, x, 6'b0, y};
   endfunction

   function automatic logic [15:0] br(input logic [2:0] c,
                                      input logic [8:0] v);
      return {3'b001, 1'b0, c, v};
   endfunction

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run(input int post);
      int c;
      bit done;
      KEY[3] = 1'b0;
      for (int i = 0; i < 256; i++)
         dut.mem[i] = (i < pg.size()) ? pg[i] : 16'h0;
      #15;
      @(negedge clk);
      KEY[3] = 1'b1;
      #1;
      check("rst_hex", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {6{7'h7F}});
      check("rst_ledr", LEDR, 0);
      check("rst_pc", dut.pc, 0);
      check("rst_z", dut.z, 0);
      check("rst_halt", dut.halted, 0);
      kill_cyc = 0; n_kill = 0; n_led = 0;
      n_late = 0; led_cyc = 0; halt_c = 0;
      c = 0;
      done = 0;
      while (!done) begin
         @(posedge clk);
         #1;
         c++;
         if (c == 1)
            check("fetch0", {dut.fd.v, dut.fd.pc}, {1'b1, 16'h0});
         if (dut.WriteData) begin
            if (kill_cyc != 0) n_late++;
            if (dut.DataAddr == 16'hFFFF) begin
               n_kill++;
               kill_cyc = c;
            end else if (dut.DataAddr == 16'h2000) begin
               n_led++;
            end
         end
         if (led_cyc == 0 && LEDR != 0) led_cyc = c;
         if (halt_c == 0 && dut.halted) halt_c = c;
         if (halt_c != 0 && c >= halt_c + post) done = 1;
         if (c >= 400) begin
            check("halt_timeout", dut.halted, 1);
            done = 1;
         end
      end
      check("kill_once", n_kill, 1);
   endtask

   initial begin
      KEY = 4'hF;
      SW  = 10'h2A5;
      #2;

      // switches -> HEX, plain load and load-use
      pg = '{ii(MVT,5,9'h030), ii(MVT,6,9'h010),
             ii(MV,7,9'd0),    ii(SUB,7,9'd1),
             rr(LD,3,5),       NOP,
             rr(ST,3,6),       ii(ADD,6,9'd1),
             rr(LD,3,5),       rr(ST,3,6),
             rr(LD,2,6),       rr(ST,4,7)};
      run(0);
      check("b_hex0", HEX0, 7'h25);
      check("b_hex1", HEX1, 7'h25);
      check("b_hex2", HEX2, 7'h7F);
      check("b_r3", dut.r[3], 16'h02A5);
      check("b_r2", dut.r[2], 16'h0025);
      check("b_kill_cyc", kill_cyc, 14);

      // ALU and LEDR
      pg = '{ii(MV,1,9'd5),   ii(ADD,1,9'd3),
             ii(MVT,2,9'h020), rr(ST,1,2),
             ii(MV,7,9'd0),   ii(SUB,7,9'd1),
             ii(SUB,1,9'd8),  rr(ST,4,7)};
      run(0);
      check("a_ledr", LEDR, 10'h008);
      check("a_led_cyc", led_cyc, 6);
      check("a_r1", dut.r[1], 16'h0000);
      check("a_z", dut.z, 1);
      check("a_r2", dut.r[2], 16'h2000);
      check("a_r7", dut.r[7], 16'hFFFF);
      check("a_kill_cyc", kill_cyc, 9);

      // countdown loop with b!Z
      pg = '{ii(MV,1,9'd3),   ii(MVT,2,9'h020),
             ii(MV,7,9'd0),   ii(SUB,7,9'd1),
             ii(ADD,6,9'd1),  ii(SUB,1,9'd1),
             br(3'd2,9'h1FD), rr(ST,1,2),
             ii(MV,3,9'd9),   rr(ST,4,7)};
      run(0);
      check("c_iters", dut.r[6], 16'd3);
      check("c_r1", dut.r[1], 16'd0);
      check("c_led_writes", n_led, 1);
      check("c_ledr", LEDR, 10'h000);
      check("c_r3", dut.r[3], 16'd9);
      check("c_kill_cyc", kill_cyc, 19);

      // RAM store->load bypass, unmapped address
      pg = '{ii(MV,1,9'h080), ii(MV,0,9'h1AB),
             rr(ST,0,1),      rr(LD,2,1),
             ii(MVT,3,9'h040), ii(MV,4,9'd7),
             rr(ST,4,3),      rr(LD,4,3),
             ii(MV,7,9'd0),   ii(SUB,7,9'd1),
             rr(ST,5,7)};
      run(0);
      check("d_r2", dut.r[2], 16'h01AB);
      check("d_mem80", dut.mem[8'h80], 16'h01AB);
      check("d_unmapped", dut.r[4], 16'h0000);
      check("d_kill_cyc", kill_cyc, 12);

      // kill, then stay halted
      pg = '{ii(MVT,2,9'h020), ii(MV,1,9'h055),
             ii(MV,0,9'd0),    ii(SUB,0,9'd1),
             rr(ST,4,0),       rr(ST,1,2),
             ii(ADD,5,9'd1)};
      run(100);
      check("f_kill_cyc", kill_cyc, 6);
      check("f_late_stores", n_late, 0);
      check("f_ledr", LEDR, 10'h000);
      check("f_hex0", HEX0, 7'h7F);
      check("f_r5", dut.r[5], 16'h0000);
      check("f_r0", dut.r[0], 16'hFFFF);
      check("f_pc", dut.pc, 16'd5);
      check("f_halt", dut.halted, 1);

      // back-to-back forwarding, not-taken branch, and
      pg = '{ii(MV,1,9'd0),   ii(ADD,1,9'd1),
             ii(ADD,1,9'd1),  ii(ADD,1,9'd1),
             ii(ADD,1,9'd1),  br(3'd1,9'd5),
             ii(MV,2,9'h00F), rr(AND,2,1),
             ii(MV,7,9'd0),   ii(SUB,7,9'd1),
             rr(ST,4,7)};
      run(0);
      check("e_r1", dut.r[1], 16'd4);
      check("e_r2", dut.r[2], 16'd4);
      check("e_kill_cyc", kill_cyc, 12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
